// File: rtl/wisc_mem_pkg.sv
// Shared types and default widths for the unified memory arbiter and its requesters.
package wisc_mem_pkg;

   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_DATA_W = 16;

   typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_MEM} arb_state_t;

   typedef enum logic {OWN_IF, OWN_MEM} owner_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch, data and backing-memory signals around the arbiter.
// slave is the arbiter side; master is the pipeline/memory side.
interface unified_mem_arbiter_if
   import wisc_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_cancel;
   logic              if_done;
   logic [DATA_W-1:0] if_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;

   logic              stall_if;
   logic              stall_mem;

   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_ready;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  if_req, if_addr, if_cancel, mem_req, mem_we, mem_addr, mem_wdata,
             ram_ready, ram_rdata,
      output if_done, if_rdata, mem_done, mem_rdata, stall_if, stall_mem,
             ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr, if_cancel, mem_req, mem_we, mem_addr, mem_wdata,
             ram_ready, ram_rdata,
      input  if_done, if_rdata, mem_done, mem_rdata, stall_if, stall_mem,
             ram_en, ram_we, ram_addr, ram_wdata
   );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of MEM wins over a waiting fetch; at_max forces the next tie to IF.
module arb_starve_ctr #(
   parameter int unsigned MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic at_max
);

   localparam int unsigned CW = (MAX > 0) ? $clog2(MAX + 1) : 1;

   logic [CW-1:0] cnt_q;

   // Clear has priority over increment; count saturates at MAX.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && !at_max) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Saturation flag used by the arbiter tie-break.
   always_comb begin
      at_max = (cnt_q >= CW'(MAX));
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch (IF) and load/store (MEM).
// MEM wins ties unless IF has lost STARVE_MAX ties in a row.
module unified_mem_arbiter
   import wisc_mem_pkg::*;
#(
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic                  clk,
   input logic                  rst,
   unified_mem_arbiter_if.slave bus
);

   arb_state_t        state_q, state_d;
   owner_t            owner;
   logic              if_elig, mem_elig;
   logic              grant_if, grant_mem;
   logic              if_complete, mem_complete;
   logic              if_deliver;
   logic              starve_inc, at_max;
   logic              cancel_flag_q;
   logic              if_done_q, mem_done_q;
   logic              ram_we_q;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;

   // Eligibility, grant decision and next state.
   always_comb begin
      if_elig   = bus.if_req & ~if_done_q & ~bus.if_cancel;
      mem_elig  = bus.mem_req & ~mem_done_q;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      state_d   = state_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (mem_elig && (!if_elig || !at_max)) begin
               grant_mem = 1'b1;
               state_d   = ARB_MEM;
            end else if (if_elig) begin
               grant_if = 1'b1;
               state_d  = ARB_IF;
            end
         end
         ARB_IF, ARB_MEM: begin
            if (bus.ram_ready) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Completion decode; a redirect in the completing cycle also drops the fetch.
   always_comb begin
      owner        = (state_q == ARB_MEM) ? OWN_MEM : OWN_IF;
      if_complete  = (state_q != ARB_IDLE) && bus.ram_ready && (owner == OWN_IF);
      mem_complete = (state_q != ARB_IDLE) && bus.ram_ready && (owner == OWN_MEM);
      if_deliver   = if_complete && !cancel_flag_q && !bus.if_cancel;
      starve_inc   = grant_mem & bus.if_req & ~bus.if_cancel;
   end

   arb_starve_ctr #(
      .MAX (STARVE_MAX)
   ) u_starve_ctr (
      .clk    (clk),
      .rst    (rst),
      .inc    (starve_inc),
      .clr    (grant_if),
      .at_max (at_max)
   );

   // State, done pulses and the cancel marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ARB_IDLE;
         if_done_q     <= 1'b0;
         mem_done_q    <= 1'b0;
         cancel_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         if_done_q  <= if_deliver;
         mem_done_q <= mem_complete;
         if (if_complete) begin
            cancel_flag_q <= 1'b0;
         end else if (((state_q == ARB_IF) || grant_if) && bus.if_cancel) begin
            cancel_flag_q <= 1'b1;
         end
      end
   end

   // Command latch on grant; fields hold until the access completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else if (grant_mem) begin
         ram_we_q    <= bus.mem_we;
         ram_addr_q  <= bus.mem_addr;
         ram_wdata_q <= bus.mem_wdata;
      end else if (grant_if) begin
         ram_we_q   <= 1'b0;
         ram_addr_q <= bus.if_addr;
      end
   end

   // Read data capture; stores and cancelled fetches leave the registers alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
      end else begin
         if (if_deliver) if_rdata_q <= bus.ram_rdata;
         if (mem_complete && !ram_we_q) mem_rdata_q <= bus.ram_rdata;
      end
   end

   assign bus.ram_en    = (state_q != ARB_IDLE);
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.mem_done  = mem_done_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.stall_if  = bus.if_req & ~if_done_q;
   assign bus.stall_mem = bus.mem_req & ~mem_done_q;

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-port unified instruction/data memory between two requesters: the IF stage (fetch) and the MEM stage (load/store).
- Grants one access at a time through a ready-handshake backing-memory interface.
- Returns read data and a one-cycle completion pulse to the owning requester.
- Drives per-stage stall lines so the pipeline holds while an access is outstanding.
- MEM has priority. A starvation counter guarantees forward progress for IF. A redirect cancel discards stale fetches.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
STARVE_MAX, 4, consecutive MEM wins over a pending IF request before IF is forced to win

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, level; held with if_addr stable until if_done
if_addr  in  ADDR_W  fetch address
if_cancel  in  1  PC redirect (branch/call/ret taken); invalidates current/pending fetch
if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetched instruction, registered, held until next IF completion
mem_req  in  1  data request, level; held with addr/we/wdata stable until mem_done
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_done  out  1  one-cycle pulse: data access complete
mem_rdata  out  DATA_W  load data, registered, unchanged on stores
stall_if  out  1  if_req & ~if_done (combinational)
stall_mem  out  1  mem_req & ~mem_done (combinational)
ram_en  out  1  command valid to backing memory
ram_we  out  1  command is write
ram_addr  out  ADDR_W  command address
ram_wdata  out  DATA_W  command write data
ram_ready  in  1  memory accepts/completes command this cycle; ram_rdata valid when high and ram_we=0
ram_rdata  in  DATA_W  memory read data

Behaviour:
- Reset:
  - state=ARB_IDLE; starve_cnt=0; cancel_flag=0.
  - if_done=0, mem_done=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, mem_rdata=0.
  - Reset mid-transaction abandons the access: no done pulse; ram_en is 0 the next cycle.
- FSM states: ARB_IDLE, ARB_IF, ARB_MEM.
- Request eligibility in ARB_IDLE:
  - A request is eligible unless that port's done is high this cycle. Requesters drop req in the done cycle.
  - if_req is ineligible while if_cancel=1.
- Arbitration in ARB_IDLE:
  - Only MEM eligible -> ARB_MEM.
  - Only IF eligible -> ARB_IF.
  - Both eligible -> ARB_MEM if starve_cnt < STARVE_MAX, else ARB_IF.
- Command latch: on the grant edge, latch the winner's addr (and we/wdata for MEM; IF is always a read) into ram_addr/ram_we/ram_wdata.
- ram_en = (state != ARB_IDLE). Command fields stay stable until completion.
- Busy states:
  - Wait indefinitely for ram_ready; there is no timeout.
  - On ram_ready, the next state is ARB_IDLE.
  - Next cycle: the owner's done=1 for exactly one cycle, and its rdata register captures ram_rdata (reads only).
- Minimum latency: request sampled at edge N; ram_en in cycle N; ram_ready in cycle N; done in cycle N+1.
- Throughput: at most one access per 2 cycles. The arbiter can grant the other port in the done cycle.
- if_cancel:
  - In ARB_IF, or in ARB_IDLE on the edge IF is granted: set cancel_flag.
  - The RAM access still completes, but if_done is suppressed and if_rdata is not updated. cancel_flag clears on completion.
  - No effect on MEM transactions.
- starve_cnt (saturating at STARVE_MAX):
  - +1 on each MEM grant while if_req=1 and if_cancel=0.
  - Cleared on every IF grant.
  - Unchanged otherwise.
- Stalls: stall_if and stall_mem are purely combinational from req/done. A cancelled fetch keeps stall_if asserted only while if_req stays high.
- Simultaneous ram_ready and new requests: a grant only happens from ARB_IDLE. Requests are held, never lost.

Decomposition:
- Shared package wisc_mem_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_IF, ARB_MEM}
  - typedef enum logic owner_t {OWN_IF, OWN_MEM}
  - ADDR_W/DATA_W defaults, reused by IF_Unit and MEM_Unit.
- One sub-module: arb_starve_ctr, a saturating counter with inc/clr/at_max.

Test Plan:
1. Assert rst for 2 cycles during an ARB_MEM access with ram_ready=0 -> all outputs 0 the cycle after reset; no mem_done afterwards.
2. IF only: if_req=1, if_addr=0x0010, ram_ready=1 in cycle after grant, ram_rdata=0xB123 -> ram_en 1 cycle, ram_addr=0x0010, if_done pulse next cycle, if_rdata=0xB123, stall_if 1 until done.
3. Both requesting, MEM store addr=0x0040 wdata=0xBEEF -> MEM first (ram_we=1, ram_wdata=0xBEEF), mem_done pulse, IF granted in the done cycle, if_done 2 cycles later.
4. Starvation: if_req held high, mem_req re-asserted every idle cycle, STARVE_MAX=4 -> 4 MEM grants, then IF granted, starve_cnt back to 0.
5. Cancel: IF grant at addr 0x0020, if_cancel pulsed while ram_ready=0 for 3 cycles -> RAM access completes, no if_done, if_rdata unchanged; new if_addr=0x0100 granted next idle cycle.
6. Load with ram_ready delayed 5 cycles, rdata=0x7F00 -> command fields stable 5 cycles, mem_done once, mem_rdata=0x7F00, stall_mem high exactly until done.
